// File: rtl/lsu_pkg.sv
// lsu_pkg: shared LSU/memory request and response types plus dmem controller state and counter width.
package lsu_pkg;
  typedef struct packed {
    logic        write_en;
    logic        read_en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } lsu_to_mem_s;
  typedef struct packed {
    logic        w_success;
    logic        r_success;
    logic [31:0] data;
  } mem_to_lsu_s;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;
  localparam int DMEM_LAT_W = 4;
endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH x 32 single-port synchronous SRAM with byte-enable writes and a held read register.
module dmem_sram #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               be,
  input  logic                     we,
  input  logic                     re,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
  // The read register keeps the last read word until the next read.
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: IDLE/WAIT/DONE data-memory controller with LATENCY wait states.
// Define DMEM_BOUNDS_CHECK_EN to flag out-of-range accesses on access_err_o.
module dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        arst_n,
  input  lsu_to_mem_s lsu_to_mem_i,
  output mem_to_lsu_s mem_to_lsu_o,
  output logic        busy_o
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic        access_err_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  dmem_state_t state, state_nx;
  logic [DMEM_LAT_W-1:0] cnt, cnt_nx;
  lsu_to_mem_s req;
  logic [31:0] off, rdata;
  logic fire, oor, do_wr, do_rd, w_ok, r_ok, unused_bits;
  assign off   = req.addr - BASE_ADDR;
  assign fire  = state == WAIT && cnt == '0;
  assign do_wr = fire && req.write_en;
  assign do_rd = fire && !req.write_en && req.read_en;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic err, zero_q;
  assign oor          = |off[31:AW+2];
  assign unused_bits  = ^off[1:0];
  assign access_err_o = err;
  assign mem_to_lsu_o = {w_ok, r_ok, zero_q ? 32'h0 : rdata};
`else
  assign oor          = 1'b0;
  assign unused_bits  = ^{off[31:AW+2], off[1:0]};
  assign mem_to_lsu_o = {w_ok, r_ok, rdata};
`endif
  assign busy_o = state != IDLE;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (lsu_to_mem_i.write_en || lsu_to_mem_i.read_en) begin
        state_nx = WAIT;
        cnt_nx   = DMEM_LAT_W'(LATENCY);
      end
      WAIT: if (cnt == '0) state_nx = DONE;
            else cnt_nx = cnt - 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
      w_ok  <= 1'b0;
      r_ok  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE) req <= lsu_to_mem_i;
      w_ok  <= do_wr;
      r_ok  <= do_rd;
    end
`ifdef DMEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      err    <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      err <= fire && oor;
      if (do_rd) zero_q <= oor;
    end
`endif
  // The array is touched only on the WAIT->DONE edge, so a reset abort never writes.
  dmem_sram #(.DEPTH(DEPTH)) u_sram (
    .clk   (clk),
    .arst_n(arst_n),
    .addr  (off[AW+1:2]),
    .wdata (req.data),
    .be    (req.strb),
    .we    (do_wr && !oor),
    .re    (do_rd && !oor),
    .rdata (rdata)
  );
endmodule
